// File: rtl/instr_decode_stage.sv
// Decode stage for the 19-bit CPU: splits instruction words into fields and classes.
// The output register plus one skid entry sustain full throughput; illegal opcodes can halt intake.
//
// state  | meaning
// S_RUN  | accepting fetch words whenever the skid entry is free
// S_HALT | illegal opcode accepted; intake stopped, buffered words still drain; flush resumes
module instr_decode_stage #(
  parameter int PC_W            = 19,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [18:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [2:0]      out_rd,
  output logic [2:0]      out_rs1,
  output logic [2:0]      out_rs2,
  output logic [18:0]     out_imm,
  output logic            out_is_alu,
  output logic            out_is_branch,
  output logic            out_is_mem,
  output logic            out_is_special,
  output logic            out_reg_we,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_illegal,
  output logic            halted
);

  localparam logic [4:0] OP_NOT  = 5'b00000;
  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_OR   = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_MUL  = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;
  localparam logic [4:0] OP_INC  = 5'b01000;
  localparam logic [4:0] OP_DEC  = 5'b01001;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_BEQ  = 5'b01101;
  localparam logic [4:0] OP_BNE  = 5'b01110;
  localparam logic [4:0] OP_CALL = 5'b01111;
  localparam logic [4:0] OP_RET  = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ST   = 5'b10010;
  localparam logic [4:0] OP_FFT  = 5'b10011;
  localparam logic [4:0] OP_ENC  = 5'b10100;
  localparam logic [4:0] OP_DCR  = 5'b10101;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      opcode;
    logic [2:0]      rd;
    logic [2:0]      rs1;
    logic [2:0]      rs2;
    logic [18:0]     imm;
    logic            is_alu;
    logic            is_branch;
    logic            is_mem;
    logic            is_special;
    logic            reg_we;
    logic            mem_rd;
    logic            mem_wr;
    logic            illegal;
  } bundle_t;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t  state_q, state_d;
  bundle_t dec;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_full_q, skid_full_d;
  logic    rdy_q, rdy_d;
  logic    accept;

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[18:14];
    unique case (in_instr[18:14])
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        dec.is_alu = 1'b1;
        dec.rd     = in_instr[13:11];
        dec.rs1    = in_instr[10:8];
        dec.rs2    = in_instr[7:5];
        dec.reg_we = 1'b1;
      end
      // Single-operand ALU ops ignore the rs2 slot.
      OP_NOT, OP_INC, OP_DEC: begin
        dec.is_alu = 1'b1;
        dec.rd     = in_instr[13:11];
        dec.rs1    = in_instr[10:8];
        dec.reg_we = 1'b1;
      end
      OP_FFT, OP_ENC, OP_DCR: begin
        dec.is_special = 1'b1;
        dec.rd         = in_instr[13:11];
        dec.rs1        = in_instr[10:8];
        dec.rs2        = in_instr[7:5];
        dec.reg_we     = 1'b1;
      end
      OP_LD: begin
        dec.is_mem = 1'b1;
        dec.rd     = in_instr[13:11];
        dec.imm    = {8'b0, in_instr[10:0]};
        dec.reg_we = 1'b1;
        dec.mem_rd = 1'b1;
      end
      OP_ST: begin
        dec.is_mem = 1'b1;
        dec.rs2    = in_instr[13:11];
        dec.imm    = {8'b0, in_instr[10:0]};
        dec.mem_wr = 1'b1;
      end
      OP_JMP, OP_CALL: begin
        dec.is_branch = 1'b1;
        dec.imm       = {8'b0, in_instr[10:0]};
      end
      OP_BEQ, OP_BNE: begin
        dec.is_branch = 1'b1;
        dec.rs1       = in_instr[13:11];
        dec.rs2       = in_instr[10:8];
        dec.imm       = {{11{in_instr[7]}}, in_instr[7:0]};
      end
      OP_RET: dec.is_branch = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign in_ready = rdy_q && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
      state_d     = S_RUN;
    end else begin
      if (!out_valid_q || out_ready) begin
        // Skid entry is older than any incoming word; it always goes first.
        if (skid_full_q) begin
          out_d       = skid_q;
          out_valid_d = 1'b1;
          skid_full_d = 1'b0;
        end else if (accept) begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d      = dec;
        skid_full_d = 1'b1;
      end
      if (accept && dec.illegal && HALT_ON_ILLEGAL) state_d = S_HALT;
    end
    rdy_d = !skid_full_d && (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      rdy_q       <= rdy_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_q.pc;
  assign out_opcode     = out_q.opcode;
  assign out_rd         = out_q.rd;
  assign out_rs1        = out_q.rs1;
  assign out_rs2        = out_q.rs2;
  assign out_imm        = out_q.imm;
  assign out_is_alu     = out_q.is_alu;
  assign out_is_branch  = out_q.is_branch;
  assign out_is_mem     = out_q.is_mem;
  assign out_is_special = out_q.is_special;
  assign out_reg_we     = out_q.reg_we;
  assign out_mem_rd     = out_q.mem_rd;
  assign out_mem_wr     = out_q.mem_wr;
  assign out_illegal    = out_q.illegal;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: field decode, skid buffering, halt, flush and reset.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [18:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_opcode;
  logic [2:0]  out_rd, out_rs1, out_rs2;
  logic        out_is_alu, out_is_branch, out_is_mem, out_is_special;
  logic        out_reg_we, out_mem_rd, out_mem_wr, out_illegal, halted;
  logic [4:0]  cls;
  logic [2:0]  en;
  logic [8:0]  regs;
  int          checks = 0;
  int          fails  = 0;

  instr_decode_stage #(.PC_W(19), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_is_alu(out_is_alu), .out_is_branch(out_is_branch), .out_is_mem(out_is_mem),
    .out_is_special(out_is_special), .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_illegal(out_illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  // class order {alu, branch, mem, special, illegal}; enables {reg_we, mem_rd, mem_wr}
  assign cls  = {out_is_alu, out_is_branch, out_is_mem, out_is_special, out_illegal};
  assign en   = {out_reg_we, out_mem_rd, out_mem_wr};
  assign regs = {out_rd, out_rs1, out_rs2};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [18:0] instr, input logic [18:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #12;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if ({cls, en, regs, out_imm, out_pc, out_opcode} !== '0) begin fails++; $display("FAIL reset_fields: got nonzero bundle, imm %h pc %h", out_imm, out_pc); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
    tick;
    rst_n = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    drive(1'b1, {5'b00100, 3'd1, 3'd2, 3'd3, 5'd0}, 19'h00010);
    tick;
    drive(1'b1, {5'b10001, 3'd5, 11'h7FF}, 19'h00011);
    checks++; if (out_valid !== 1'b1 || out_pc !== 19'h00010) begin fails++; $display("FAIL add_valid_pc: got %b/%h expected 1/00010", out_valid, out_pc); end
    checks++; if (regs !== {3'd1, 3'd2, 3'd3}) begin fails++; $display("FAIL add_regs: got %h expected %h", regs, {3'd1, 3'd2, 3'd3}); end
    checks++; if (cls !== 5'b10000 || en !== 3'b100 || out_imm !== 19'h0) begin fails++; $display("FAIL add_class: got %b/%b/%h expected 10000/100/0", cls, en, out_imm); end
    tick;
    drive(1'b0, '0, '0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 19'h00011) begin fails++; $display("FAIL ld_valid_pc: got %b/%h expected 1/00011", out_valid, out_pc); end
    checks++; if (regs !== {3'd5, 3'd0, 3'd0} || out_imm !== 19'h007FF) begin fails++; $display("FAIL ld_fields: got %h/%h expected %h/007ff", regs, out_imm, {3'd5, 6'd0}); end
    checks++; if (cls !== 5'b00100 || en !== 3'b110) begin fails++; $display("FAIL ld_class: got %b/%b expected 00100/110", cls, en); end
    tick;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_decode_table;
    logic [18:0] tv_instr [10];
    logic [4:0]  tv_cls   [10];
    logic [8:0]  tv_regs  [10];
    logic [18:0] tv_imm   [10];
    logic [2:0]  tv_en    [10];
    tv_instr[0] = {5'b01101, 3'd1, 3'd2, 8'hF0};       tv_cls[0] = 5'b01000; tv_regs[0] = {3'd0, 3'd1, 3'd2}; tv_imm[0] = 19'h7FFF0; tv_en[0] = 3'b000;
    tv_instr[1] = {5'b01101, 3'd3, 3'd4, 8'h10};       tv_cls[1] = 5'b01000; tv_regs[1] = {3'd0, 3'd3, 3'd4}; tv_imm[1] = 19'h00010; tv_en[1] = 3'b000;
    tv_instr[2] = {5'b01110, 3'd7, 3'd0, 8'h80};       tv_cls[2] = 5'b01000; tv_regs[2] = {3'd0, 3'd7, 3'd0}; tv_imm[2] = 19'h7FF80; tv_en[2] = 3'b000;
    tv_instr[3] = {5'b01100, 3'd6, 11'h5A5};           tv_cls[3] = 5'b01000; tv_regs[3] = 9'd0;               tv_imm[3] = 19'h005A5; tv_en[3] = 3'b000;
    tv_instr[4] = {5'b01111, 3'd0, 11'h7FF};           tv_cls[4] = 5'b01000; tv_regs[4] = 9'd0;               tv_imm[4] = 19'h007FF; tv_en[4] = 3'b000;
    tv_instr[5] = {5'b10000, 14'h3FFF};                tv_cls[5] = 5'b01000; tv_regs[5] = 9'd0;               tv_imm[5] = 19'h00000; tv_en[5] = 3'b000;
    tv_instr[6] = {5'b10010, 3'd6, 11'h123};           tv_cls[6] = 5'b00100; tv_regs[6] = {3'd0, 3'd0, 3'd6}; tv_imm[6] = 19'h00123; tv_en[6] = 3'b001;
    tv_instr[7] = {5'b00000, 3'd2, 3'd3, 3'd7, 5'h1F}; tv_cls[7] = 5'b10000; tv_regs[7] = {3'd2, 3'd3, 3'd0}; tv_imm[7] = 19'h00000; tv_en[7] = 3'b100;
    tv_instr[8] = {5'b10011, 3'd1, 3'd4, 3'd5, 5'd0};  tv_cls[8] = 5'b00010; tv_regs[8] = {3'd1, 3'd4, 3'd5}; tv_imm[8] = 19'h00000; tv_en[8] = 3'b100;
    tv_instr[9] = {5'b01001, 3'd7, 3'd6, 3'd5, 5'd0};  tv_cls[9] = 5'b10000; tv_regs[9] = {3'd7, 3'd6, 3'd0}; tv_imm[9] = 19'h00000; tv_en[9] = 3'b100;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tv_instr[i], 19'h00300 + 19'(i));
      tick;
      checks++; if (out_valid !== 1'b1 || out_pc !== 19'h00300 + 19'(i)) begin fails++; $display("FAIL dec%0d_pc: got %b/%h expected 1/%h", i, out_valid, out_pc, 19'h00300 + 19'(i)); end
      checks++; if (cls !== tv_cls[i]) begin fails++; $display("FAIL dec%0d_class: got %b expected %b", i, cls, tv_cls[i]); end
      checks++; if (regs !== tv_regs[i]) begin fails++; $display("FAIL dec%0d_regs: got %h expected %h", i, regs, tv_regs[i]); end
      checks++; if (out_imm !== tv_imm[i]) begin fails++; $display("FAIL dec%0d_imm: got %h expected %h", i, out_imm, tv_imm[i]); end
      checks++; if (en !== tv_en[i] || out_opcode !== tv_instr[i][18:14]) begin fails++; $display("FAIL dec%0d_en_op: got %b/%b expected %b/%b", i, en, out_opcode, tv_en[i], tv_instr[i][18:14]); end
    end
    drive(1'b0, '0, '0);
    tick;
  endtask

  task automatic test_back_to_back_stall;
    out_ready = 1'b0;
    drive(1'b1, {5'b00100, 3'd1, 3'd0, 3'd0, 5'd0}, 19'h00100);
    tick;
    checks++; if (out_pc !== 19'h00100 || in_ready !== 1'b1) begin fails++; $display("FAIL stall_c1: got pc %h rdy %b expected 00100/1", out_pc, in_ready); end
    drive(1'b1, {5'b00100, 3'd2, 3'd0, 3'd0, 5'd0}, 19'h00101);
    tick;
    checks++; if (out_pc !== 19'h00100 || in_ready !== 1'b0) begin fails++; $display("FAIL stall_c2: got pc %h rdy %b expected 00100/0", out_pc, in_ready); end
    drive(1'b1, {5'b00100, 3'd3, 3'd0, 3'd0, 5'd0}, 19'h00102);
    for (int c = 3; c <= 4; c++) begin
      tick;
      checks++; if (out_valid !== 1'b1 || out_pc !== 19'h00100 || out_rd !== 3'd1 || in_ready !== 1'b0) begin fails++; $display("FAIL stall_c%0d: got v%b pc %h rd %0d rdy %b expected 1/00100/1/0", c, out_valid, out_pc, out_rd, in_ready); end
    end
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b1 || out_pc !== 19'h00101 || out_rd !== 3'd2 || in_ready !== 1'b1) begin fails++; $display("FAIL release_b: got v%b pc %h rd %0d rdy %b expected 1/00101/2/1", out_valid, out_pc, out_rd, in_ready); end
    tick;
    drive(1'b0, '0, '0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 19'h00102 || out_rd !== 3'd3) begin fails++; $display("FAIL release_c: got v%b pc %h rd %0d expected 1/00102/3", out_valid, out_pc, out_rd); end
    tick;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL release_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_illegal_halt;
    out_ready = 1'b1;
    drive(1'b1, {5'b01011, 14'h3FFF}, 19'h00200);
    tick;
    drive(1'b1, {5'b00011, 3'd4, 3'd5, 3'd6, 5'd0}, 19'h00201);
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || cls !== 5'b00001) begin fails++; $display("FAIL ill_class: got v%b cls %b expected 1/00001", out_valid, cls); end
    checks++; if (en !== 3'b000 || regs !== 9'd0 || out_imm !== 19'h0 || out_opcode !== 5'b01011 || out_pc !== 19'h00200) begin fails++; $display("FAIL ill_fields: got en %b regs %h imm %h op %b pc %h", en, regs, out_imm, out_opcode, out_pc); end
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL ill_halt: got halted %b rdy %b expected 1/0", halted, in_ready); end
    tick;
    tick;
    checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL halt_hold: got v%b halted %b rdy %b expected 0/1/0", out_valid, halted, in_ready); end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_cycle_rdy: got %b expected 0", in_ready); end
    tick;
    flush = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL unhalt: got halted %b rdy %b v%b expected 0/1/0", halted, in_ready, out_valid); end
    tick;
    drive(1'b0, '0, '0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 19'h00201 || regs !== {3'd4, 3'd5, 3'd6} || cls !== 5'b10000) begin fails++; $display("FAIL xor_after_flush: got v%b pc %h regs %h cls %b", out_valid, out_pc, regs, cls); end
    tick;
  endtask

  task automatic test_flush_full;
    out_ready = 1'b0;
    drive(1'b1, {5'b00101, 3'd1, 3'd1, 3'd1, 5'd0}, 19'h00400);
    tick;
    drive(1'b1, {5'b00101, 3'd2, 3'd2, 3'd2, 5'd0}, 19'h00401);
    tick;
    drive(1'b1, {5'b00101, 3'd3, 3'd3, 3'd3, 5'd0}, 19'h00402);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_clear: got v%b rdy %b expected 0/1", out_valid, in_ready); end
    drive(1'b1, {5'b00101, 3'd4, 3'd4, 3'd4, 5'd0}, 19'h00403);
    out_ready = 1'b1;
    tick;
    drive(1'b0, '0, '0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 19'h00403 || out_rd !== 3'd4) begin fails++; $display("FAIL flush_next: got v%b pc %h rd %0d expected 1/00403/4", out_valid, out_pc, out_rd); end
    tick;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_stale: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(1'b1, {5'b00110, 3'd5, 3'd6, 3'd7, 5'd0}, 19'h00500);
    tick;
    drive(1'b1, {5'b00110, 3'd6, 3'd6, 3'd7, 5'd0}, 19'h00501);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL async_valid: got v%b halted %b expected 0/0", out_valid, halted); end
    checks++; if ({cls, en, regs, out_imm, out_pc, out_opcode} !== '0) begin fails++; $display("FAIL async_fields: got regs %h pc %h op %b expected 0", regs, out_pc, out_opcode); end
    drive(1'b0, '0, '0);
    tick;
    rst_n = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL post_reset: got rdy %b v%b expected 1/0", in_ready, out_valid); end
    out_ready = 1'b1;
    tick;
    tick;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_stale: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_decode_table;
    test_back_to_back_stall;
    test_illegal_halt;
    test_flush_full;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
